// File: rtl/atm_session_if.sv
// -----------------------------------------------------------------------------
// atm_session_if
// Groups the card/keypad inputs and the status/cash outputs of the ATM session
// controller into one bundle.
//   master : the card reader / keypad side (drives card and key inputs,
//            observes the controller's status outputs)
//   slave  : the session controller itself
// Signals:
//   card_in        card present level
//   key_valid      one-cycle strobe qualifying key_code / pin_in / amount_in
//   key_code[2:0]  001 withdraw, 010 deposit, 011 balance, 100 exit
//   pin_in         PIN entry
//   amount_in      transaction amount
//   y_out[2:0]     current state encoding
//   y_out_flash    error indicator
//   balance_out    current balance
//   dispense_valid one-cycle cash pulse, dispense_amt valid with it
//   card_locked    lockout active
//   err_code[1:0]  00 none, 01 bad PIN, 10 insufficient/zero, 11 overflow
// -----------------------------------------------------------------------------
interface atm_session_if #(
  parameter int PIN_W = 4,
  parameter int BAL_W = 16
);
  logic             card_in;
  logic             key_valid;
  logic [2:0]       key_code;
  logic [PIN_W-1:0] pin_in;
  logic [BAL_W-1:0] amount_in;

  logic [2:0]       y_out;
  logic             y_out_flash;
  logic [BAL_W-1:0] balance_out;
  logic             dispense_valid;
  logic [BAL_W-1:0] dispense_amt;
  logic             card_locked;
  logic [1:0]       err_code;

  modport master (
    output card_in, key_valid, key_code, pin_in, amount_in,
    input  y_out, y_out_flash, balance_out, dispense_valid, dispense_amt,
           card_locked, err_code
  );

  modport slave (
    input  card_in, key_valid, key_code, pin_in, amount_in,
    output y_out, y_out_flash, balance_out, dispense_valid, dispense_amt,
           card_locked, err_code
  );
endinterface

// File: rtl/atm_session_ctrl.sv
// -----------------------------------------------------------------------------
// atm_session_ctrl
// Session controller for a single-account ATM: card insertion, PIN check with
// lockout after MAX_TRIES consecutive wrong PINs, withdraw / deposit / balance
// menu, idle-key timeout, and an error flash indicator.
//
// Ports:
//   clock  single clock, rising edge
//   reset  synchronous, active-high; returns every register to its reset value
//   bus    atm_session_if.slave (card/key inputs, status/cash outputs)
//
// Timing: the session state reacts at the edge that samples an input; every
// output is a register loaded from that state on the following edge, so an
// input sampled at edge N shows up on the outputs after edge N+1.
// -----------------------------------------------------------------------------
module atm_session_ctrl #(
  parameter int               PIN_W       = 4,
  parameter logic [PIN_W-1:0] PIN_VAL     = 4'b1010,
  parameter int               BAL_W       = 16,
  parameter int               INIT_BAL    = 1000,
  parameter int               MAX_TRIES   = 3,
  parameter int               FLASH_CYC   = 4,
  parameter int               TIMEOUT_CYC = 16
) (
  input  logic          clock,
  input  logic          reset,
  atm_session_if.slave  bus
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int FL_W  = $clog2(FLASH_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_PIN     = 3'b001,
    ST_MENU    = 3'b010,
    ST_WDRAW   = 3'b011,
    ST_DEPOSIT = 3'b100,
    ST_BALSHOW = 3'b101,
    ST_LOCKED  = 3'b110,
    ST_EJECT   = 3'b111
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_PIN   = 2'b01,
    ERR_FUNDS = 2'b10,
    ERR_OVF   = 2'b11
  } err_t;

  // ---------------------------------------------------------------------------
  // Session state
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [BAL_W-1:0] bal_q;
  logic [TRY_W-1:0] tries_q;     // consecutive wrong PINs, survives eject
  logic [TMO_W-1:0] tmo_q;       // cycles without key_valid in an active state
  logic [FL_W-1:0]  flash_q;     // remaining flash cycles
  err_t             err_q;
  logic             disp_q;      // successful withdraw happened this edge
  logic [BAL_W-1:0] disp_amt_q;

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [2:0]       y_out_q;
  logic             flash_out_q;
  logic [BAL_W-1:0] bal_out_q;
  logic             dv_q;
  logic [BAL_W-1:0] da_q;
  logic             locked_q;
  logic [1:0]       err_out_q;

  // ---------------------------------------------------------------------------
  // Transaction qualifiers
  // ---------------------------------------------------------------------------
  logic [BAL_W:0]   dep_sum;
  logic             dep_ovf;
  logic             wd_ok;
  logic             pin_ok;
  logic [TRY_W-1:0] tries_inc;
  logic             tries_hit;
  logic             timeout_hit;

  // One extra bit holds the deposit carry, which is exactly the overflow flag.
  assign dep_sum     = {1'b0, bal_q} + {1'b0, bus.amount_in};
  assign dep_ovf     = dep_sum[BAL_W];
  assign wd_ok       = (bus.amount_in != '0) && (bus.amount_in <= bal_q);
  assign pin_ok      = (bus.pin_in == PIN_VAL);
  assign tries_inc   = tries_q + 1'b1;
  assign tries_hit   = (tries_inc >= TRY_W'(MAX_TRIES));
  // tmo_q counts the idle cycles already seen; this edge would be number
  // TIMEOUT_CYC.
  assign timeout_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // ---------------------------------------------------------------------------
  // Session FSM and output stage
  // ---------------------------------------------------------------------------
  // NOTE: every register here is written with <= so all right-hand sides see
  // the pre-edge values; when two assignments hit the same register in one
  // pass (a default followed by a specific case), the later one wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bal_q       <= BAL_W'(INIT_BAL);
      tries_q     <= '0;
      tmo_q       <= '0;
      flash_q     <= '0;
      err_q       <= ERR_NONE;
      disp_q      <= 1'b0;
      disp_amt_q  <= '0;
      y_out_q     <= ST_IDLE;
      flash_out_q <= 1'b0;
      bal_out_q   <= BAL_W'(INIT_BAL);
      dv_q        <= 1'b0;
      da_q        <= '0;
      locked_q    <= 1'b0;
      err_out_q   <= ERR_NONE;
    end else begin
      // Output stage: publish the state reached at the previous edge.
      y_out_q     <= state_q;
      flash_out_q <= (flash_q != '0);
      bal_out_q   <= bal_q;
      dv_q        <= disp_q;
      if (disp_q) begin
        da_q <= disp_amt_q;
      end
      locked_q    <= (state_q == ST_LOCKED);
      err_out_q   <= err_q;

      // Defaults, overridden below by the events of this edge.
      disp_q <= 1'b0;
      if (flash_q != '0) begin
        flash_q <= flash_q - 1'b1;
      end
      tmo_q <= '0;

      case (state_q)
        ST_IDLE: begin
          if (bus.card_in) begin
            state_q <= ST_PIN;
          end
        end

        ST_PIN, ST_MENU, ST_WDRAW, ST_DEPOSIT: begin
          if (!bus.card_in) begin
            // Card removal beats any key strobed in the same cycle.
            state_q <= ST_EJECT;
          end else if (!bus.key_valid) begin
            tmo_q <= tmo_q + 1'b1;
            if (timeout_hit) begin
              state_q <= ST_EJECT;
            end
          end else if (state_q == ST_PIN) begin
            if (pin_ok) begin
              tries_q <= '0;
              state_q <= ST_MENU;
            end else begin
              tries_q <= tries_inc;
              err_q   <= ERR_PIN;
              flash_q <= FL_W'(FLASH_CYC);
              state_q <= tries_hit ? ST_LOCKED : ST_PIN;
            end
          end else if (state_q == ST_MENU) begin
            // Only a recognised menu code counts as accepted and clears err.
            case (bus.key_code)
              3'b001: begin state_q <= ST_WDRAW;   err_q <= ERR_NONE; end
              3'b010: begin state_q <= ST_DEPOSIT; err_q <= ERR_NONE; end
              3'b011: begin state_q <= ST_BALSHOW; err_q <= ERR_NONE; end
              3'b100: begin state_q <= ST_EJECT;   err_q <= ERR_NONE; end
              default: ;
            endcase
          end else if (state_q == ST_WDRAW) begin
            if (wd_ok) begin
              bal_q      <= bal_q - bus.amount_in;
              disp_q     <= 1'b1;
              disp_amt_q <= bus.amount_in;
            end else begin
              err_q   <= ERR_FUNDS;
              flash_q <= FL_W'(FLASH_CYC);
            end
            state_q <= ST_MENU;
          end else begin
            if (dep_ovf) begin
              err_q   <= ERR_OVF;
              flash_q <= FL_W'(FLASH_CYC);
            end else begin
              bal_q <= dep_sum[BAL_W-1:0];
            end
            state_q <= ST_MENU;
          end
        end

        ST_BALSHOW: state_q <= ST_MENU;

        ST_LOCKED:  state_q <= ST_LOCKED;

        ST_EJECT:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.y_out          = y_out_q;
  assign bus.y_out_flash    = flash_out_q;
  assign bus.balance_out    = bal_out_q;
  assign bus.dispense_valid = dv_q;
  assign bus.dispense_amt   = da_q;
  assign bus.card_locked    = locked_q;
  assign bus.err_code       = err_out_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_atm_session_ctrl
// Directed session scenarios with literal expectations, followed by randomized
// card/key traffic. A behavioural account model predicts every output; one
// compare process checks the DUT against it on each falling edge.
// -----------------------------------------------------------------------------
module tb_atm_session_ctrl;

  localparam int         PIN_W       = 4;
  localparam int         BAL_W       = 16;
  localparam int         INIT_BAL    = 1000;
  localparam int         MAX_TRIES   = 3;
  localparam int         FLASH_CYC   = 4;
  localparam int         TIMEOUT_CYC = 16;
  localparam logic [3:0] PIN_OK      = 4'b1010;
  localparam int         BAL_MAX     = (1 << BAL_W) - 1;

  // State codes as seen on y_out.
  localparam int IDLE = 0, PIN = 1, MENU = 2, WDRAW = 3, DEPOSIT = 4,
                 BALSHOW = 5, LOCKED = 6, EJECT = 7;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  atm_session_if #(.PIN_W(PIN_W), .BAL_W(BAL_W)) bus ();

  atm_session_ctrl #(
    .PIN_W(PIN_W), .PIN_VAL(PIN_OK), .BAL_W(BAL_W), .INIT_BAL(INIT_BAL),
    .MAX_TRIES(MAX_TRIES), .FLASH_CYC(FLASH_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: account + session as plain integers. The m_* values
  // are the session after each edge; e_* are what the outputs must show,
  // i.e. the session one edge earlier.
  // ---------------------------------------------------------------------------
  int m_state, m_bal, m_tries, m_idle, m_flash, m_err, m_disp, m_damt;
  int e_y, e_flash, e_bal, e_dv, e_da, e_lock, e_err;
  bit model_ok = 1'b0;

  task automatic model_reset();
    m_state = IDLE; m_bal = INIT_BAL; m_tries = 0; m_idle = 0;
    m_flash = 0; m_err = 0; m_disp = 0; m_damt = 0;
    e_y = IDLE; e_flash = 0; e_bal = INIT_BAL; e_dv = 0; e_da = 0;
    e_lock = 0; e_err = 0;
  endtask

  task automatic model_key();
    int amt;
    amt = int'(bus.amount_in);
    case (m_state)
      PIN: begin
        if (bus.pin_in == PIN_OK) begin
          m_tries = 0;
          m_state = MENU;
        end else begin
          m_tries++;
          m_err   = 1;
          m_flash = FLASH_CYC;
          m_state = (m_tries >= MAX_TRIES) ? LOCKED : PIN;
        end
      end
      MENU: begin
        case (int'(bus.key_code))
          1: begin m_state = WDRAW;   m_err = 0; end
          2: begin m_state = DEPOSIT; m_err = 0; end
          3: begin m_state = BALSHOW; m_err = 0; end
          4: begin m_state = EJECT;   m_err = 0; end
          default: ;
        endcase
      end
      WDRAW: begin
        if (amt > 0 && amt <= m_bal) begin
          m_bal  = m_bal - amt;
          m_disp = 1;
          m_damt = amt;
        end else begin
          m_err   = 2;
          m_flash = FLASH_CYC;
        end
        m_state = MENU;
      end
      default: begin  // DEPOSIT
        if (m_bal + amt > BAL_MAX) begin
          m_err   = 3;
          m_flash = FLASH_CYC;
        end else begin
          m_bal = m_bal + amt;
        end
        m_state = MENU;
      end
    endcase
  endtask

  task automatic model_step();
    e_y     = m_state;
    e_flash = (m_flash > 0) ? 1 : 0;
    e_bal   = m_bal;
    e_dv    = m_disp;
    if (m_disp != 0) e_da = m_damt;
    e_lock  = (m_state == LOCKED) ? 1 : 0;
    e_err   = m_err;

    if (m_flash > 0) m_flash--;
    m_disp = 0;

    case (m_state)
      IDLE: if (bus.card_in) begin m_state = PIN; m_idle = 0; end
      PIN, MENU, WDRAW, DEPOSIT: begin
        if (!bus.card_in) m_state = EJECT;
        else if (bus.key_valid) begin
          m_idle = 0;
          model_key();
        end else begin
          m_idle++;
          if (m_idle >= TIMEOUT_CYC) m_state = EJECT;
        end
      end
      BALSHOW: m_state = MENU;
      LOCKED:  ;
      default: m_state = IDLE;  // EJECT
    endcase
    if (!(m_state inside {PIN, MENU, WDRAW, DEPOSIT})) m_idle = 0;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      model_reset();
      model_ok = 1'b1;
    end else if (model_ok) begin
      model_step();
    end
  end

  always @(negedge clock) begin
    if (model_ok) begin
      check("y_out",          bus.y_out,          e_y);
      check("y_out_flash",    bus.y_out_flash,    e_flash);
      check("balance_out",    bus.balance_out,    e_bal);
      check("dispense_valid", bus.dispense_valid, e_dv);
      check("card_locked",    bus.card_locked,    e_lock);
      check("err_code",       bus.err_code,       e_err);
      if (e_dv != 0) check("dispense_amt", bus.dispense_amt, e_da);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs are applied just after a rising edge and held for
  // exactly one sampling edge; helpers return 1 time unit after that edge.
  // ---------------------------------------------------------------------------
  task automatic cyc(input bit card, input bit kv, input logic [2:0] code,
                     input logic [3:0] pin, input logic [15:0] amt);
    bus.card_in   = card;
    bus.key_valid = kv;
    bus.key_code  = code;
    bus.pin_in    = pin;
    bus.amount_in = amt;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input bit card);
    cyc(card, 1'b0, 3'b000, 4'b0000, 16'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1'b0);
    idle(1'b0);
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_y"},     bus.y_out,          0);
    check({tag, "_bal"},   bus.balance_out,    INIT_BAL);
    check({tag, "_flash"}, bus.y_out_flash,    0);
    check({tag, "_dv"},    bus.dispense_valid, 0);
    check({tag, "_da"},    bus.dispense_amt,   0);
    check({tag, "_lock"},  bus.card_locked,    0);
    check({tag, "_err"},   bus.err_code,       0);
  endtask

  // Reset, insert card, enter the right PIN; returns with MENU on y_out.
  task automatic login();
    do_reset();
    idle(1'b1);
    cyc(1'b1, 1'b1, 3'b000, PIN_OK, 16'd0);
    idle(1'b1);
  endtask

  initial begin
    bus.card_in = 1'b0; bus.key_valid = 1'b0; bus.key_code = '0;
    bus.pin_in = '0; bus.amount_in = '0;

    // Reset values and the basic withdraw session.
    do_reset();
    check_reset_vals("rst");
    idle(1'b1);
    idle(1'b1);
    check("wd_y_pin", bus.y_out, PIN);
    cyc(1'b1, 1'b1, 3'b000, PIN_OK, 16'd0);
    idle(1'b1);
    check("wd_y_menu", bus.y_out, MENU);
    cyc(1'b1, 1'b1, 3'b001, 4'b0000, 16'd0);
    idle(1'b1);
    check("wd_y_wdraw", bus.y_out, WDRAW);
    cyc(1'b1, 1'b1, 3'b000, 4'b0000, 16'd300);
    check("wd_dv_early", bus.dispense_valid, 0);
    idle(1'b1);
    check("wd_dv",   bus.dispense_valid, 1);
    check("wd_da",   bus.dispense_amt,   300);
    check("wd_bal",  bus.balance_out,    700);
    check("wd_y_back", bus.y_out,        MENU);
    idle(1'b1);
    check("wd_dv_one", bus.dispense_valid, 0);

    // Three wrong PINs lock the card; nothing but reset gets it out.
    do_reset();
    idle(1'b1);
    for (int t = 0; t < 3; t++) begin
      cyc(1'b1, 1'b1, 3'b000, 4'b0000, 16'd0);
      for (int k = 0; k < FLASH_CYC; k++) begin
        idle(1'b1);
        check("pin_flash_on", bus.y_out_flash, 1);
        check("pin_err",      bus.err_code,    1);
      end
      idle(1'b1);
      check("pin_flash_off", bus.y_out_flash, 0);
    end
    check("lock_y",    bus.y_out,       LOCKED);
    check("lock_flag", bus.card_locked, 1);
    idle(1'b0);
    idle(1'b1);
    cyc(1'b1, 1'b1, 3'b000, PIN_OK, 16'd0);
    idle(1'b1);
    idle(1'b1);
    check("lock_hold_y",    bus.y_out,       LOCKED);
    check("lock_hold_flag", bus.card_locked, 1);

    // Wrong-PIN count survives eject and re-insertion.
    do_reset();
    idle(1'b1);
    cyc(1'b1, 1'b1, 3'b000, 4'b0001, 16'd0);
    idle(1'b1);
    cyc(1'b1, 1'b1, 3'b000, 4'b0010, 16'd0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    cyc(1'b1, 1'b1, 3'b000, 4'b0011, 16'd0);
    idle(1'b1);
    check("persist_lock", bus.y_out, LOCKED);

    // Over-withdraw and zero withdraw.
    login();
    cyc(1'b1, 1'b1, 3'b001, 4'b0000, 16'd0);
    cyc(1'b1, 1'b1, 3'b000, 4'b0000, 16'd1001);
    idle(1'b1);
    check("ovw_err",   bus.err_code,       2);
    check("ovw_flash", bus.y_out_flash,    1);
    check("ovw_bal",   bus.balance_out,    1000);
    check("ovw_dv",    bus.dispense_valid, 0);
    check("ovw_y",     bus.y_out,          MENU);
    for (int k = 1; k < FLASH_CYC; k++) idle(1'b1);
    idle(1'b1);
    check("ovw_flash_end", bus.y_out_flash, 0);
    cyc(1'b1, 1'b1, 3'b001, 4'b0000, 16'd0);
    cyc(1'b1, 1'b1, 3'b000, 4'b0000, 16'd0);
    idle(1'b1);
    check("zero_err",   bus.err_code,       2);
    check("zero_bal",   bus.balance_out,    1000);
    check("zero_dv",    bus.dispense_valid, 0);
    check("zero_flash", bus.y_out_flash,    1);

    // Deposit overflow, then a normal deposit.
    login();
    cyc(1'b1, 1'b1, 3'b010, 4'b0000, 16'd0);
    cyc(1'b1, 1'b1, 3'b000, 4'b0000, 16'd65000);
    idle(1'b1);
    check("dep_ovf_err", bus.err_code,    3);
    check("dep_ovf_bal", bus.balance_out, 1000);
    cyc(1'b1, 1'b1, 3'b010, 4'b0000, 16'd0);
    cyc(1'b1, 1'b1, 3'b000, 4'b0000, 16'd500);
    idle(1'b1);
    check("dep_bal", bus.balance_out, 1500);
    check("dep_err", bus.err_code,    0);

    // Idle-key timeout in MENU.
    login();
    for (int k = 0; k < TIMEOUT_CYC - 1; k++) begin
      idle(1'b1);
      check("tmo_menu", bus.y_out, MENU);
    end
    idle(1'b1);
    check("tmo_eject", bus.y_out, EJECT);
    idle(1'b1);
    check("tmo_idle", bus.y_out, IDLE);

    // Card pulled in the same cycle as the withdraw amount.
    login();
    cyc(1'b1, 1'b1, 3'b001, 4'b0000, 16'd0);
    cyc(1'b0, 1'b1, 3'b000, 4'b0000, 16'd300);
    idle(1'b0);
    check("pull_y",   bus.y_out,          EJECT);
    check("pull_bal", bus.balance_out,    1000);
    check("pull_dv",  bus.dispense_valid, 0);
    idle(1'b0);
    check("pull_idle", bus.y_out, IDLE);

    // Reset mid-withdraw after two wrong PINs in an earlier session.
    do_reset();
    idle(1'b1);
    cyc(1'b1, 1'b1, 3'b000, 4'b0000, 16'd0);
    idle(1'b1);
    cyc(1'b1, 1'b1, 3'b000, 4'b0000, 16'd0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    cyc(1'b1, 1'b1, 3'b000, PIN_OK, 16'd0);
    cyc(1'b1, 1'b1, 3'b001, 4'b0000, 16'd0);
    cyc(1'b1, 1'b1, 3'b000, 4'b0000, 16'd100);
    idle(1'b1);
    check("mid_da", bus.dispense_amt, 100);
    cyc(1'b1, 1'b1, 3'b001, 4'b0000, 16'd0);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 3'b000, 4'b0000, 16'd300);
    idle(1'b1);
    reset = 1'b0;
    check_reset_vals("mid_rst");
    idle(1'b1);
    cyc(1'b1, 1'b1, 3'b000, 4'b0000, 16'd0);
    idle(1'b1);
    check("mid_one_wrong_y",    bus.y_out,       PIN);
    check("mid_one_wrong_lock", bus.card_locked, 0);

    // Reset in PIN after two wrong PINs clears the try count.
    do_reset();
    idle(1'b1);
    cyc(1'b1, 1'b1, 3'b000, 4'b0111, 16'd0);
    cyc(1'b1, 1'b1, 3'b000, 4'b0111, 16'd0);
    do_reset();
    idle(1'b1);
    cyc(1'b1, 1'b1, 3'b000, 4'b0111, 16'd0);
    idle(1'b1);
    check("rst_tries_y", bus.y_out, PIN);

    // Randomized traffic: busy keys first, sparse keys later for timeouts.
    for (int n = 0; n < 4000; n++) begin
      bit         card, kv;
      logic [2:0] code;
      logic [3:0] pin;
      logic [15:0] amt;
      int         kv_pct;
      if ($urandom_range(0, 299) == 0 ||
          (m_state == LOCKED && $urandom_range(0, 7) == 0)) begin
        reset = 1'b1;
        idle(1'b0);
        reset = 1'b0;
        continue;
      end
      kv_pct = (n < 2000) ? 40 : 8;
      if (m_state == IDLE || m_state == EJECT) card = ($urandom_range(0, 9) < 7);
      else                                     card = ($urandom_range(0, 99) < 97);
      kv   = ($urandom_range(0, 99) < kv_pct);
      code = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                         : 3'($urandom_range(1, 4));
      pin  = ($urandom_range(0, 9) < 7) ? PIN_OK : 4'($urandom);
      case ($urandom_range(0, 4))
        0:       amt = 16'd0;
        1:       amt = 16'($urandom_range(1, 400));
        2:       amt = 16'(m_bal);
        3:       amt = 16'(m_bal + 1);
        default: amt = 16'($urandom);
      endcase
      cyc(card, kv, code, pin, amt);
    end

    idle(1'b0);
    idle(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
